// File: rtl/alu_rr_sequencer.sv
// Round-robin front end for a shared combinational ALU: accepts one op at a time from two
// requesters, holds operands on the ALU for SETTLE_CYC cycles, then returns result and flags.
module alu_rr_sequencer #(
    parameter int WIDTH      = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_ovf,
    output logic             resp_carry,
    output logic             resp_err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_busA,
    output logic [WIDTH-1:0] alu_busB,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_carry
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             last_r;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic             sel_id_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [3:0]       sel_op_s;
    logic             sel_ok_s;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6: op_supported = 1'b1;
            default:                            op_supported = 1'b0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = sel_ok_s ? EXEC : RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant and ready outputs; the requester that did not win last time wins a tie
    always_comb begin
        grant0_s = req0_valid & (~req1_valid | last_r);
        grant1_s = req1_valid & (~req0_valid | ~last_r);
        if ((state_r == IDLE) && !reset) begin
            req0_ready = grant0_s;
            req1_ready = grant1_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        accept_s = req0_ready | req1_ready;
        sel_id_s = req1_ready;
        sel_a_s  = req1_ready ? req1_a  : req0_a;
        sel_b_s  = req1_ready ? req1_b  : req0_b;
        sel_op_s = req1_ready ? req1_op : req0_op;
        sel_ok_s = op_supported(sel_op_s);
    end

    // Datapath: operand hold on the ALU, settle counter, response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= {CW{1'b0}};
            last_r      <= 1'b1;
            busy        <= 1'b0;
            alu_busA    <= {WIDTH{1'b0}};
            alu_busB    <= {WIDTH{1'b0}};
            alu_ctrl    <= 4'd0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= {WIDTH{1'b0}};
            resp_zero   <= 1'b0;
            resp_ovf    <= 1'b0;
            resp_carry  <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            busy <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        last_r  <= sel_id_s;
                        resp_id <= sel_id_s;
                        if (sel_ok_s) begin
                            alu_busA <= sel_a_s;
                            alu_busB <= sel_b_s;
                            alu_ctrl <= sel_op_s;
                            cnt_r    <= CW'(SETTLE_CYC - 1);
                        end else begin
                            // Error ops skip the ALU entirely and answer with zeros
                            resp_valid  <= 1'b1;
                            resp_err    <= 1'b1;
                            resp_result <= {WIDTH{1'b0}};
                            resp_zero   <= 1'b0;
                            resp_ovf    <= 1'b0;
                            resp_carry  <= 1'b0;
                        end
                    end else begin
                        resp_valid <= 1'b0;
                    end
                end
                EXEC: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b0;
                        resp_result <= alu_out;
                        resp_zero   <= alu_zero;
                        resp_ovf    <= alu_ovf;
                        resp_carry  <= alu_carry;
                        alu_busA    <= {WIDTH{1'b0}};
                        alu_busB    <= {WIDTH{1'b0}};
                        alu_ctrl    <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end else begin
                        resp_valid <= 1'b1;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a small behavioural ALU on the alu_* side;
// expected values are hand-computed constants.
module tb_alu_rr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_result;
    logic        resp_zero, resp_ovf, resp_carry, resp_err, busy;
    logic [31:0] alu_busA, alu_busB, alu_out;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, alu_ovf, alu_carry;
    logic [32:0] sum33;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.WIDTH(32), .SETTLE_CYC(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .resp_ovf(resp_ovf), .resp_carry(resp_carry), .resp_err(resp_err),
        .busy(busy), .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_carry(alu_carry)
    );

    // Behavioural ALU; carry is the no-borrow carry-out for sub
    always_comb begin
        sum33     = 33'd0;
        alu_out   = 32'd0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_ctrl)
            4'd0: begin
                sum33     = {1'b0, alu_busA} + {1'b0, alu_busB};
                alu_out   = sum33[31:0];
                alu_carry = sum33[32];
                alu_ovf   = (alu_busA[31] == alu_busB[31]) && (alu_out[31] != alu_busA[31]);
            end
            4'd1: begin
                sum33     = {1'b0, alu_busA} + {1'b0, ~alu_busB} + 33'd1;
                alu_out   = sum33[31:0];
                alu_carry = sum33[32];
                alu_ovf   = (alu_busA[31] != alu_busB[31]) && (alu_out[31] != alu_busA[31]);
            end
            4'd2:    alu_out = alu_busA ^ alu_busB;
            4'd3:    alu_out = ($signed(alu_busA) < $signed(alu_busB)) ? 32'd1 : 32'd0;
            4'd5:    alu_out = alu_busA << alu_busB[4:0];
            4'd6:    alu_out = alu_busA >> alu_busB[4:0];
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b0;
        tick();
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_alu_busA", alu_busA, 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] exp_r, input logic exp_z, input logic exp_v, input logic exp_c,
                          input logic exp_e, input int stall, input string tag);
        int lat;
        logic [31:0] held;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        #1;
        check({tag, "_ready"}, 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_alu_busA"}, alu_busA, exp_e ? 32'd0 : a);
        check({tag, "_alu_ctrl"}, 32'(alu_ctrl), exp_e ? 32'd0 : 32'(op));
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (exp_e) check({tag, "_alu_busB"}, alu_busB, 32'd0);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), exp_e ? 32'd1 : 32'd3);
        check({tag, "_id"}, 32'(resp_id), 32'(id));
        check({tag, "_result"}, resp_result, exp_r);
        check({tag, "_flags_zvce"}, 32'({resp_zero, resp_ovf, resp_carry, resp_err}),
              32'({exp_z, exp_v, exp_c, exp_e}));
        check({tag, "_alu_idle"}, alu_busA | alu_busB | 32'(alu_ctrl), 32'd0);
        held = resp_result;
        if (stall > 0) begin
            req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd0; req0_valid = 1'b1;
            req1_a = 32'd2; req1_b = 32'd2; req1_op = 4'd0; req1_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_valid_busy"}, 32'({resp_valid, busy}), 32'd3);
            check({tag, "_stall_result"}, resp_result, held);
            check({tag, "_stall_readies"}, 32'({req1_ready, req0_ready}), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_done_valid_busy"}, 32'({resp_valid, busy}), 32'd0);
    endtask

    initial begin
        reset = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
        tick();
        do_reset();

        run_op(1'b0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 0, "add5_7");

        // Both requesters valid: grants alternate starting at req0 after reset
        do_reset();
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd0;
        req1_a = 32'd3; req1_b = 32'd5; req1_op = 4'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int lat;
            #1;
            check("rr_grant", 32'({req1_ready, req0_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            lat = 1;
            while (!resp_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("rr_latency", 32'(lat), 32'd3);
            check("rr_id", 32'(resp_id), 32'(k % 2));
            check("rr_result", resp_result, (k % 2 == 0) ? 32'd2 : 32'd6);
            resp_ready = 1'b1;
            #1;
            check("rr_no_reaccept", 32'({req1_ready, req0_ready}), 32'd0);
            tick();
            resp_ready = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        run_op(1'b1, 32'd9, 32'd9, 4'b0100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "err_op4");
        run_op(1'b0, 32'd9, 32'd9, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "err_opF");
        run_op(1'b0, 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, "sub0_1");
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "add_carry");
        run_op(1'b0, 32'h7FFF_FFFF, 32'd1, 4'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 0, "add_ovf");
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "slt");
        run_op(1'b0, 32'd3, 32'd2, 4'd5, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 0, "sll");
        run_op(1'b1, 32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 10, "srl_stall");

        // Reset in EXEC after a req0 grant: op dropped and req0 wins the next tie again
        req0_a = 32'd4; req0_b = 32'd4; req0_op = 4'd0; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("exec_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_alu_busA", alu_busA, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("rst_exec_no_resp", 32'(resp_valid), 32'd0);
            tick();
        end
        req1_a = 32'd1; req1_b = 32'd1; req1_op = 4'd0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_exec_grant", 32'({req1_ready, req0_ready}), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        run_op(1'b0, 32'd10, 32'd20, 4'd0, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
